// File: rtl/multu_pkg.sv
// Shared definitions for the unsigned multiply control and datapath:
// operand width and the encodings of the a_s and add0 control lines.
package multu_pkg;

    localparam int MULTU_WIDTH = 32;

    // Phase select on a_s: add step, then shift step.
    typedef enum logic {
        ADD   = 1'b0,
        SHIFT = 1'b1
    } a_s_e;

    // Addend select on add0 during the add step.
    typedef enum logic {
        ADD_MCAND = 1'b0,
        ADD_ZERO  = 1'b1
    } add0_e;

endpackage

// File: rtl/multu_acc_adder.sv
// Accumulator adder for the shift-add multiplier: WIDTH-bit unsigned add
// with the carry out presented separately so it can land in the product
// register's extra top bit.
module multu_acc_adder
    import multu_pkg::*;
#(
    parameter int WIDTH = MULTU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH:0] full;

    assign full  = {1'b0, a} + {1'b0, b};
    assign sum   = full[WIDTH-1:0];
    assign carry = full[WIDTH];

endmodule

// File: rtl/multu_datapath.sv
// Shift-add unsigned multiplier datapath. A 2*WIDTH+1 bit product register
// starts as {0, zeros, multiplier}; each add step conditionally adds the
// multiplicand into the upper half (carry in the top bit) and each shift
// step moves the whole register right by one. After WIDTH add/shift pairs
// the low 2*WIDTH bits hold the product.
//
// Optional feature macro MULTU_HILO_EN: adds hi/lo capture registers and a
// result_valid/result_ack handshake. Without it, hi/lo are taken straight
// from the product register and result_valid simply follows mult_done.
module multu_datapath
    import multu_pkg::*;
#(
    parameter int WIDTH = MULTU_WIDTH
) (
    input  logic             mClk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] mcand_in,
    input  logic [WIDTH-1:0] mplier_in,
    input  logic             add0,
    input  logic             a_s,
    input  logic             mult_done,
    input  logic             result_ack,
    output logic             prod_LSB,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             result_valid
);

    logic [2*WIDTH:0] prod;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] add_sum;
    logic             add_carry;

    multu_acc_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a     (prod[2*WIDTH-1:WIDTH]),
        .b     (mcand),
        .sum   (add_sum),
        .carry (add_carry)
    );

    // Product and multiplicand registers: load, then add/shift until frozen.
    always_ff @(posedge mClk or posedge reset) begin
        if (reset) begin
            prod  <= '0;
            mcand <= '0;
        end else if (load) begin
            prod  <= {1'b0, {WIDTH{1'b0}}, mplier_in};
            mcand <= mcand_in;
        end else if (!mult_done) begin
            if (a_s == SHIFT) begin
                // Carry in the top bit drops into bit 2W-1; top bit clears.
                prod <= {1'b0, prod[2*WIDTH:1]};
            end else if (add0 == ADD_MCAND) begin
                prod[2*WIDTH:WIDTH] <= {add_carry, add_sum};
            end
        end
    end

    // Zero-latency so the control can decide this cycle's add.
    assign prod_LSB = prod[0];

`ifdef MULTU_HILO_EN
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             valid_q;
    logic             armed;

    // Capture hi/lo once per load on the first mult_done, then hold valid until acked.
    always_ff @(posedge mClk or posedge reset) begin
        if (reset) begin
            hi_q    <= '0;
            lo_q    <= '0;
            valid_q <= 1'b0;
            armed   <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b0;
            armed   <= 1'b1;
        end else if (mult_done && armed) begin
            // Capture beats a coincident acknowledge.
            hi_q    <= prod[2*WIDTH-1:WIDTH];
            lo_q    <= prod[WIDTH-1:0];
            valid_q <= 1'b1;
            armed   <= 1'b0;
        end else if (result_ack) begin
            valid_q <= 1'b0;
        end
    end

    assign hi           = hi_q;
    assign lo           = lo_q;
    assign result_valid = valid_q;
`else
    logic unused_ack;

    assign unused_ack   = result_ack;
    assign hi           = prod[2*WIDTH-1:WIDTH];
    assign lo           = prod[WIDTH-1:0];
    assign result_valid = mult_done & ~load & ~reset;
`endif

endmodule

// File: tb/tb_multu_datapath.sv
// Directed bench for multu_datapath. The bench plays the multiply control:
// it loads operands, runs add/shift pairs choosing add0 from prod_LSB, and
// raises mult_done. Expected products are hand-computed constants.
module tb_multu_datapath;
    import multu_pkg::*;

    localparam int W = 32;

    logic         mClk = 1'b0;
    logic         reset = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] mcand_in = '0;
    logic [W-1:0] mplier_in = '0;
    logic         add0 = 1'b1;
    logic         a_s = 1'b0;
    logic         mult_done = 1'b0;
    logic         result_ack = 1'b0;
    logic         prod_LSB;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         result_valid;

    int total = 0;
    int bad = 0;
    logic saw_lsb = 1'b0;
    logic saw_valid = 1'b0;

    multu_datapath #(
        .WIDTH (W)
    ) dut (
        .mClk         (mClk),
        .reset        (reset),
        .load         (load),
        .mcand_in     (mcand_in),
        .mplier_in    (mplier_in),
        .add0         (add0),
        .a_s          (a_s),
        .mult_done    (mult_done),
        .result_ack   (result_ack),
        .prod_LSB     (prod_LSB),
        .hi           (hi),
        .lo           (lo),
        .result_valid (result_valid)
    );

    always #5 mClk = ~mClk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Load operands; returns at the negedge after the load edge.
    task automatic do_load(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge mClk);
        load      = 1'b1;
        mult_done = 1'b0;
        a_s       = ADD;
        add0      = ADD_ZERO;
        mcand_in  = a;
        mplier_in = b;
        saw_lsb   = 1'b0;
        saw_valid = 1'b0;
        @(negedge mClk);
        load = 1'b0;
    endtask

    // Run n add/shift pairs, choosing add0 from prod_LSB like the control.
    task automatic do_pairs(input int n);
        for (int i = 0; i < n; i++) begin
            a_s  = ADD;
            add0 = prod_LSB ? ADD_MCAND : ADD_ZERO;
            if (prod_LSB) saw_lsb = 1'b1;
            if (result_valid) saw_valid = 1'b1;
            @(negedge mClk);
            a_s  = SHIFT;
            add0 = ADD_ZERO;
            if (result_valid) saw_valid = 1'b1;
            @(negedge mClk);
        end
    endtask

    // Raise mult_done and let the capture edge pass.
    task automatic do_done();
        mult_done = 1'b1;
        a_s       = ADD;
        @(negedge mClk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2 reset = 1'b1;
        #2;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_lsb", prod_LSB, 0);
        @(negedge mClk);
        reset = 1'b0;

        // 3 * 5
        do_load(32'd3, 32'd5);
        chk("load_lsb_5", prod_LSB, 1);
        do_pairs(32);
        do_done();
        chk("m3x5_hi", hi, 32'h0000_0000);
        chk("m3x5_lo", lo, 32'h0000_000F);
        chk("m3x5_valid", result_valid, 1);
        chk("m3x5_lsb", prod_LSB, 1);
        // Frozen while mult_done is high, even with a shift request.
        a_s = SHIFT;
        @(negedge mClk);
        @(negedge mClk);
        chk("freeze_lo", lo, 32'h0000_000F);
        chk("freeze_hi", hi, 32'h0000_0000);
        a_s = ADD;

        // Carry path: all ones squared
        do_load(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_pairs(32);
        do_done();
        chk("mmax_hi", hi, 32'hFFFF_FFFE);
        chk("mmax_lo", lo, 32'h0000_0001);

        // Zero multiplier: no add ever taken
        do_load(32'h1234_5678, 32'd0);
        do_pairs(32);
        do_done();
        chk("mzero_hi", hi, 0);
        chk("mzero_lo", lo, 0);
        chk("mzero_no_lsb", saw_lsb, 0);

        // Reset mid-operation
        do_load(32'd7, 32'd9);
        do_pairs(10);
        reset = 1'b1;
        #1;
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        chk("midrst_valid", result_valid, 0);
        chk("midrst_lsb", prod_LSB, 0);
        @(negedge mClk);
        reset = 1'b0;
        do_load(32'd7, 32'd9);
        chk("load_lsb_9", prod_LSB, 1);
        do_pairs(32);
        do_done();
        chk("m7x9_lo", lo, 32'h0000_003F);
        chk("m7x9_hi", hi, 0);

        // Abort 100*100 by loading 6*7 mid-run
        do_load(32'd100, 32'd100);
        do_pairs(6);
        chk("abort_no_valid", saw_valid | result_valid, 0);
        do_load(32'd6, 32'd7);
        do_pairs(32);
        chk("m6x7_no_early_valid", saw_valid, 0);
        // Acknowledge coincident with the capture edge
        result_ack = 1'b1;
        do_done();
        chk("m6x7_lo", lo, 32'h0000_002A);
        chk("m6x7_hi", hi, 0);
        chk("ack_cap_valid", result_valid, 1);
        @(negedge mClk);
`ifdef MULTU_HILO_EN
        chk("ack_clear_valid", result_valid, 0);
`else
        chk("ack_ignored_valid", result_valid, 1);
`endif
        result_ack = 1'b0;

        // A new load drops valid; captured words survive only with capture regs
        do_load(32'd9, 32'd11);
        chk("reload_valid", result_valid, 0);
`ifdef MULTU_HILO_EN
        chk("reload_lo_held", lo, 32'h0000_002A);
`else
        chk("reload_lo_live", lo, 32'd11);
`endif
        do_pairs(32);
        do_done();
        chk("m9x11_lo", lo, 32'd99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
